// File: rtl/gray_rx_monitor_if.sv
// Count bus between a gray-code source and gray_rx_monitor: sample strobe, clear, gray input and the status outputs.
// WrapCount is present only when GRAY_WRAPCNT_EN is defined.
interface gray_rx_monitor_if #(
   parameter int WIDTH = 3
);
   logic             En;
   logic             Clear;
   logic [WIDTH-1:0] Gray;
   logic [WIDTH-1:0] Binary;
   logic             Valid;
   logic             Wrap;
   logic             StepErr;
   logic             Fault;
`ifdef GRAY_WRAPCNT_EN
   logic [7:0]       WrapCount;
`endif

   modport master (
      output En, Clear, Gray,
      input  Binary, Valid, Wrap, StepErr, Fault
`ifdef GRAY_WRAPCNT_EN
      , input WrapCount
`endif
   );

   modport slave (
      input  En, Clear, Gray,
      output Binary, Valid, Wrap, StepErr, Fault
`ifdef GRAY_WRAPCNT_EN
      , output WrapCount
`endif
   );
endinterface

// File: rtl/gray_rx_monitor.sv
// Gray-to-binary sampler that checks each sample steps by 0 or +1, flags illegal steps (sticky Fault) and wraps.
// Latency: one cycle from the En sample edge to Binary/Valid/Wrap/StepErr. Optional GRAY_WRAPCNT_EN adds WrapCount.
// No backpressure: accepts a sample on every En cycle with no bubbles.
module gray_rx_monitor #(
   parameter int WIDTH = 3
) (
   input  logic                 Clk,
   input  logic                 Reset,
   gray_rx_monitor_if.slave     bus
);
   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      LOCKED = 2'd1,
      FAULT  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] n_bin;
   logic [WIDTH-1:0] p_inc;
   logic             p_max;

   function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Binary always holds the reference sample, so it doubles as p.
   assign n_bin = g2b(bus.Gray);
   assign p_inc = bus.Binary + WIDTH'(1);
   assign p_max = &bus.Binary;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state       <= EMPTY;
         bus.Binary  <= '0;
         bus.Valid   <= 1'b0;
         bus.Wrap    <= 1'b0;
         bus.StepErr <= 1'b0;
         bus.Fault   <= 1'b0;
`ifdef GRAY_WRAPCNT_EN
         bus.WrapCount <= 8'd0;
`endif
      end else begin
         bus.Valid   <= 1'b0;
         bus.Wrap    <= 1'b0;
         bus.StepErr <= 1'b0;

         if (bus.En) begin
            bus.Binary <= n_bin;
            bus.Valid  <= 1'b1;
         end

         if (bus.Clear) begin
            // A sample taken alongside Clear becomes the fresh reference.
            bus.Fault <= 1'b0;
            state     <= bus.En ? LOCKED : EMPTY;
`ifdef GRAY_WRAPCNT_EN
            bus.WrapCount <= 8'd0;
`endif
         end else if (bus.En) begin
            case (state)
               EMPTY: state <= LOCKED;
               LOCKED: begin
                  if (n_bin == bus.Binary) begin
                     state <= LOCKED;
                  end else if (n_bin == p_inc) begin
                     if (p_max) begin
                        bus.Wrap <= 1'b1;
`ifdef GRAY_WRAPCNT_EN
                        if (bus.WrapCount != 8'hFF) bus.WrapCount <= bus.WrapCount + 8'd1;
`endif
                     end
                  end else begin
                     bus.StepErr <= 1'b1;
                     bus.Fault   <= 1'b1;
                     state       <= FAULT;
                  end
               end
               FAULT:   state <= FAULT;
               default: state <= EMPTY;
            endcase
         end
      end
   end
endmodule
